operand_input_reg: RTL and testbench

//  Serial-in / parallel-out operand register feeding the FP adder core.

---
 rtl/fp_adder_pkg.sv | 18 +
 rtl/serial_shift_in.sv | 57 +++++
 rtl/operand_input_reg.sv | 138 +++++++++++++
 tb/tb_operand_input_reg.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fp_adder_pkg.sv
// Purpose: shared constants and state encoding for the FP adder operand path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fp_adder_pkg;

    // Bits per operand (IEEE-754 single precision).
    localparam int WIDTH = 32;
    // Bit counter width; must hold values up to WIDTH-1 with margin.
    localparam int CNT_W = 6;

    // Operand register states. 2'b11 is unused and recovers to LOAD_A.
    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        FULL   = 2'b10
    } state_t;

endpackage

// File: rtl/serial_shift_in.sv
// Purpose: WIDTH-bit LSB-first serial-in shift register with a bit counter.
// Latency: word/word_done are combinational with the final accepted bit.
// Backpressure: none; the caller gates bit_vld with its own ready.
//
// Ports:
//   core_clk   clock, rising edge
//   arst_n     asynchronous reset, active-low
//   clr        synchronous clear, wins over a shift in the same cycle
//   bit_vld    accept bit_dat this cycle
//   bit_dat    serial data bit
//   word       completed word including the bit being accepted now
//   word_done  high in the cycle the WIDTH-th bit of a word is accepted
module serial_shift_in
    import fp_adder_pkg::*;
#(
    parameter int P_WIDTH = WIDTH,
    parameter int P_CNT_W = CNT_W
) (
    input  logic               core_clk,
    input  logic               arst_n,
    input  logic               clr,
    input  logic               bit_vld,
    input  logic               bit_dat,
    output logic [P_WIDTH-1:0] word,
    output logic               word_done
);

    logic [P_WIDTH-1:0] sr;
    logic [P_CNT_W-1:0] count;
    logic [P_WIDTH-1:0] sr_shifted;
    logic               last_bit;

    // First bit enters at the MSB and walks down, so after WIDTH shifts
    // the first bit received sits in bit 0.
    assign sr_shifted = {bit_dat, sr[P_WIDTH-1:1]};
    assign last_bit   = (count == P_CNT_W'(P_WIDTH - 1));

    // Completed word is presented in the same cycle as its last bit so the
    // owner can register it on that edge without an extra pipeline stage.
    assign word      = sr_shifted;
    assign word_done = bit_vld & last_bit & ~clr;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            sr    <= '0;
            count <= '0;
        end else if (clr) begin
            sr    <= '0;
            count <= '0;
        end else if (bit_vld) begin
            sr    <= sr_shifted;
            // Counter restarts at word end, so it never passes WIDTH-1.
            count <= last_bit ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/operand_input_reg.sv
// Purpose: serial-in/parallel-out operand register (A then B) for the FP adder core.
// Latency: output_rdy rises the cycle after the 2*WIDTH-th accepted bit; 1 bit/clk sustained.
// Backpressure: input_rdy drops while both operands wait; output_read_in reopens the input.
//
// Ports:
//   clk_in          clock, rising edge
//   rst_in          asynchronous reset, active-low
//   clr_in          synchronous frame clear, active-high, beats everything but reset
//   serial_in       serial data bit, LSB first, operand A then operand B
//   serial_valid_in serial_in valid this cycle
//   input_rdy       a serial bit is accepted this cycle when valid
//   op_a_out        operand A, parallel (registered)
//   op_b_out        operand B, parallel (registered)
//   output_rdy      both operands valid for the core
//   output_read_in  core consumes operands; only looked at while output_rdy=1
module operand_input_reg
    import fp_adder_pkg::*;
#(
    parameter int P_WIDTH = WIDTH,
    parameter int P_CNT_W = CNT_W
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               clr_in,
    input  logic               serial_in,
    input  logic               serial_valid_in,
    output logic               input_rdy,
    output logic [P_WIDTH-1:0] op_a_out,
    output logic [P_WIDTH-1:0] op_b_out,
    output logic               output_rdy,
    input  logic               output_read_in
);

    state_t             state;
    state_t             state_nxt;
    logic               input_rdy_nxt;
    logic               output_rdy_nxt;
    logic [P_WIDTH-1:0] op_a_nxt;
    logic [P_WIDTH-1:0] op_b_nxt;

    logic               bit_accept;
    logic [P_WIDTH-1:0] word;
    logic               word_done;

    // input_rdy is low in FULL, so bits arriving there are dropped without
    // touching the shifter or its counter.
    assign bit_accept = serial_valid_in & input_rdy;

    // One shifter serves both operands; the FSM decides where a finished
    // word lands.
    serial_shift_in #(
        .P_WIDTH (P_WIDTH),
        .P_CNT_W (P_CNT_W)
    ) u_shift (
        .core_clk  (clk_in),
        .arst_n    (rst_in),
        .clr       (clr_in),
        .bit_vld   (bit_accept),
        .bit_dat   (serial_in),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= LOAD_A;
            input_rdy  <= 1'b1;
            output_rdy <= 1'b0;
            op_a_out   <= '0;
            op_b_out   <= '0;
        end else begin
            state      <= state_nxt;
            input_rdy  <= input_rdy_nxt;
            output_rdy <= output_rdy_nxt;
            op_a_out   <= op_a_nxt;
            op_b_out   <= op_b_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        input_rdy_nxt  = input_rdy;
        output_rdy_nxt = output_rdy;
        op_a_nxt       = op_a_out;
        op_b_nxt       = op_b_out;

        if (clr_in) begin
            // Frame clear wins over any bit or read in the same cycle.
            state_nxt      = LOAD_A;
            input_rdy_nxt  = 1'b1;
            output_rdy_nxt = 1'b0;
            op_a_nxt       = '0;
            op_b_nxt       = '0;
        end else begin
            case (state)
                LOAD_A: begin
                    // A becomes visible before B starts; the core must
                    // still wait for output_rdy.
                    if (word_done) begin
                        op_a_nxt  = word;
                        state_nxt = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (word_done) begin
                        op_b_nxt       = word;
                        state_nxt      = FULL;
                        output_rdy_nxt = 1'b1;
                        input_rdy_nxt  = 1'b0;
                    end
                end
                FULL: begin
                    // Operands keep their values after the read until a
                    // new word overwrites them.
                    if (output_read_in) begin
                        state_nxt      = LOAD_A;
                        output_rdy_nxt = 1'b0;
                        input_rdy_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt      = LOAD_A;
                    input_rdy_nxt  = 1'b1;
                    output_rdy_nxt = 1'b0;
                end
            endcase
        end
    end

    // Handshake flags are mutually exclusive in every legal state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            assert (!(input_rdy && output_rdy))
                else $error("input_rdy and output_rdy both high");
        end
    end

endmodule

// File: tb/tb_operand_input_reg.sv
module tb_operand_input_reg;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        clr_in;
    logic        serial_in;
    logic        serial_valid_in;
    logic        input_rdy;
    logic [31:0] op_a_out;
    logic [31:0] op_b_out;
    logic        output_rdy;
    logic        output_read_in;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    operand_input_reg dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .clr_in          (clr_in),
        .serial_in       (serial_in),
        .serial_valid_in (serial_valid_in),
        .input_rdy       (input_rdy),
        .op_a_out        (op_a_out),
        .op_b_out        (op_b_out),
        .output_rdy      (output_rdy),
        .output_read_in  (output_read_in)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        int          gap;    // valid every gap-th cycle
        int          hold;   // FULL cycles with junk valid bits before the read
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance one clock; sample and redrive 1 ns after the rising edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_valid_in = 1'b1;
        serial_in       = b;
        step();
        serial_valid_in = 1'b0;
        serial_in       = 1'($urandom);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_op_a"},       op_a_out,          32'h0);
        chk({tag, "_op_b"},       op_b_out,          32'h0);
        chk({tag, "_input_rdy"},  {31'b0, input_rdy},  32'h1);
        chk({tag, "_output_rdy"}, {31'b0, output_rdy}, 32'h0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [63:0] stream;
        stream = {v.b, v.a};
        for (int i = 0; i < 64; i++) begin
            // Idle cycles carry junk data and a stray read, both to be ignored.
            for (int g = 1; g < v.gap; g++) begin
                serial_valid_in = 1'b0;
                serial_in       = 1'($urandom);
                output_read_in  = 1'b1;
                step();
                output_read_in  = 1'b0;
            end
            send_bit(stream[i]);
            if (i == 31) begin
                chk({v.name, "_op_a_early"}, op_a_out, v.exp_a);
                chk({v.name, "_rdy_mid"}, {31'b0, output_rdy}, 32'h0);
            end
            if (i == 62)
                chk({v.name, "_rdy_bit63"}, {31'b0, output_rdy}, 32'h0);
        end
        chk({v.name, "_output_rdy"}, {31'b0, output_rdy}, 32'h1);
        chk({v.name, "_input_rdy"},  {31'b0, input_rdy},  32'h0);
        chk({v.name, "_op_a"}, op_a_out, v.exp_a);
        chk({v.name, "_op_b"}, op_b_out, v.exp_b);

        for (int h = 0; h < v.hold; h++) begin
            send_bit(1'($urandom));
            chk({v.name, "_hold_op_a"}, op_a_out, v.exp_a);
            chk({v.name, "_hold_op_b"}, op_b_out, v.exp_b);
            chk({v.name, "_hold_rdy"}, {30'b0, output_rdy, input_rdy}, 32'h2);
        end

        output_read_in = 1'b1;
        step();
        output_read_in = 1'b0;
        chk({v.name, "_read_output_rdy"}, {31'b0, output_rdy}, 32'h0);
        chk({v.name, "_read_input_rdy"},  {31'b0, input_rdy},  32'h1);
        chk({v.name, "_read_keep_a"}, op_a_out, v.exp_a);
    endtask

    initial begin
        logic [31:0] w;

        vecs[0] = '{"one_two_b2b",  32'h3F800000, 32'h40000000, 1, 10, 32'h3F800000, 32'h40000000};
        vecs[1] = '{"one_two_gap3", 32'h3F800000, 32'h40000000, 3, 0,  32'h3F800000, 32'h40000000};
        vecs[2] = '{"ones_one",     32'hFFFFFFFF, 32'h00000001, 1, 2,  32'hFFFFFFFF, 32'h00000001};
        vecs[3] = '{"pi_max",       32'hC0490FDB, 32'h7F7FFFFF, 2, 1,  32'hC0490FDB, 32'h7F7FFFFF};

        rst_in          = 1'b0;
        clr_in          = 1'b0;
        serial_in       = 1'b0;
        serial_valid_in = 1'b0;
        output_read_in  = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check_cleared("reset");

        // Reset in the middle of operand B: all of A plus 20 bits of B.
        rst_in = 1'b1;
        step();
        w = 32'h3F800000;
        for (int i = 0; i < 32; i++) send_bit(w[i]);
        w = 32'h40000000;
        for (int i = 0; i < 20; i++) send_bit(w[i]);
        chk("midb_op_a", op_a_out, 32'h3F800000);
        #2 rst_in = 1'b0;
        #1 check_cleared("midb_reset");
        #1 rst_in = 1'b1;
        step();

        for (int k = 0; k < 3; k++) run_vec(vecs[k]);

        // Clear after 40 bits, asserted together with an accepted bit.
        w = 32'h12345678;
        for (int i = 0; i < 32; i++) send_bit(w[i]);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        clr_in          = 1'b1;
        serial_valid_in = 1'b1;
        serial_in       = 1'b1;
        step();
        clr_in          = 1'b0;
        serial_valid_in = 1'b0;
        check_cleared("clr");

        // A full frame after the clear must carry no leftover bits.
        run_vec(vecs[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute bound in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
